// File: rtl/systolic_mac_acc_pkg.sv
// systolic_mac_acc_pkg: shared state encoding and pipeline constants
package systolic_mac_acc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [1:0] LAST_DRAIN = 2'd2;
endpackage

// File: rtl/systolic_mac_acc_if.sv
// systolic_mac_acc_if: beat input stream and result output handshake
interface systolic_mac_acc_if #(
    parameter int WORD_SIZE = 32,
    parameter int ACC_BITS  = 32
);
    logic                 DI_valid;
    logic [WORD_SIZE-1:0] DI_uni;
    logic [WORD_SIZE-1:0] DI_wei;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_BITS-1:0]  res_data;
    modport master (output DI_valid, DI_uni, DI_wei, res_ready, input res_valid, res_data);
    modport slave (input DI_valid, DI_uni, DI_wei, res_ready, output res_valid, res_data);
endinterface

// File: rtl/systolic_mac_acc_lane_dot.sv
// systolic_mac_acc_lane_dot: registered int8 lane products (S1) and adder tree (S2)
module systolic_mac_acc_lane_dot #(
    parameter int LANES = 4,
    localparam int SW = 16 + $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [LANES*8-1:0]   a,
    input  logic [LANES*8-1:0]   b,
    output logic                 out_valid,
    output logic signed [SW-1:0] sum
);
    logic signed [15:0]   prod [LANES];
    logic                 v1;
    logic signed [SW-1:0] tree;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v1 <= 1'b0;
            out_valid <= 1'b0;
            sum <= '0;
            for (int k = 0; k < LANES; k++) prod[k] <= '0;
        end else begin
            v1 <= in_valid;
            out_valid <= v1;
            sum <= tree;
            for (int k = 0; k < LANES; k++) prod[k] <= $signed(a[8*k+:8]) * $signed(b[8*k+:8]);
        end
    always_comb begin
        tree = '0;
        for (int k = 0; k < LANES; k++) tree = tree + SW'(prod[k]);
    end
endmodule

// File: rtl/systolic_mac_acc.sv
// systolic_mac_acc: grouped dot-product accumulator with 2-entry result FIFO
module systolic_mac_acc
    import systolic_mac_acc_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ACC_BITS  = 32,
    parameter int LEN_BITS  = 10
) (
    input  logic                clk,
    input  logic                rst,
    systolic_mac_acc_if.slave   bus,
    input  logic                start,
    input  logic [LEN_BITS-1:0] acc_len,
    input  logic                flush,
    output logic                busy,
    output logic                ovf_err
);
    localparam int LANES = WORD_SIZE / 8;
    localparam int SW = 16 + $clog2(LANES);
    state_t                state, state_nx;
    logic [1:0]            drain_cnt;
    logic [LEN_BITS-1:0]   len_reg, cnt, cnt_inc;
    logic [ACC_BITS-1:0]   acc, acc_sum;
    logic                  d_valid, s3_valid;
    logic signed [SW-1:0]  d_sum, s3_sum;
    logic                  go, bad_start, grp_done, last_drain, push, pop, full, drop, wr;
    logic [ACC_BITS-1:0]   mem [2];
    logic                  wp, rp;
    logic [1:0]            fcnt;
    systolic_mac_acc_lane_dot #(.LANES(LANES)) u_dot (
        .clk(clk),
        .rst(rst),
        .in_valid(bus.DI_valid && state == RUN),
        .a(bus.DI_uni),
        .b(bus.DI_wei),
        .out_valid(d_valid),
        .sum(d_sum)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        go = start && state == IDLE && acc_len != '0;
        bad_start = start && state == IDLE && acc_len == '0;
        last_drain = state == DRAIN && drain_cnt == LAST_DRAIN;
        state_nx = go ? RUN : (state == RUN && flush) ? DRAIN : last_drain ? IDLE : state;
        busy = state != IDLE;
    end
    // The completing beat is folded into the pushed result, so the next group starts from zero.
    always_comb begin
        acc_sum = acc + (s3_valid ? ACC_BITS'(s3_sum) : '0);
        cnt_inc = cnt + LEN_BITS'(s3_valid);
        grp_done = s3_valid && cnt_inc == len_reg;
        push = grp_done || (last_drain && cnt_inc != '0);
        pop = bus.res_ready && fcnt != 2'd0;
        full = fcnt == 2'd2;
        drop = push && full && !pop;
        wr = push && !drop;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s3_valid <= 1'b0;
            s3_sum <= '0;
            drain_cnt <= 2'd0;
            len_reg <= '0;
            acc <= '0;
            cnt <= '0;
            ovf_err <= 1'b0;
        end else begin
            s3_valid <= d_valid;
            s3_sum <= d_sum;
            drain_cnt <= state == DRAIN ? drain_cnt + 2'd1 : 2'd0;
            len_reg <= go ? acc_len : len_reg;
            acc <= (go || grp_done || last_drain) ? '0 : acc_sum;
            cnt <= (go || grp_done || last_drain) ? '0 : cnt_inc;
            ovf_err <= go ? 1'b0 : (ovf_err || bad_start || drop);
        end
    // When full, a simultaneous pop frees the head slot that wp points at.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            fcnt <= 2'd0;
        end else begin
            if (wr) mem[wp] <= acc_sum;
            wp <= wp ^ wr;
            rp <= rp ^ pop;
            fcnt <= fcnt + 2'(wr) - 2'(pop);
        end
    assign bus.res_valid = fcnt != 2'd0;
    assign bus.res_data = mem[rp];
endmodule

// File: tb/tb_systolic_mac_acc.sv
// tb_systolic_mac_acc: table vectors, hand-written corner sequences and random runs against a group-sum model
module tb_systolic_mac_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, flush, busy, ovf_err;
    logic [9:0] acc_len;
    int         total = 0;
    int         bad = 0;
    logic [31:0] bu[$], bw[$], got[$], exp_q[$];

    typedef struct {
        logic [31:0] uni;
        logic [31:0] wei;
        logic [9:0]  len;
        int          n;
        int          exp_n;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;
    vec_t tbl[7];

    systolic_mac_acc_if #(.WORD_SIZE(32), .ACC_BITS(32)) bus ();
    systolic_mac_acc #(.WORD_SIZE(32), .ACC_BITS(32), .LEN_BITS(10)) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus),
        .start(start),
        .acc_len(acc_len),
        .flush(flush),
        .busy(busy),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && bus.res_valid && bus.res_ready) got.push_back(bus.res_data);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] dot(input logic [31:0] u, input logic [31:0] w);
        int s = 0;
        for (int k = 0; k < 4; k++) s += $signed(u[8*k+:8]) * $signed(w[8*k+:8]);
        return s;
    endfunction

    // Expected results: beats grouped by len, final partial group emitted if non-empty.
    function automatic void model(input int len);
        logic [31:0] a = 0;
        int c = 0;
        exp_q.delete();
        foreach (bu[i]) begin
            a += dot(bu[i], bw[i]);
            c++;
            if (c == len) begin
                exp_q.push_back(a);
                a = 0;
                c = 0;
            end
        end
        if (c != 0) exp_q.push_back(a);
    endfunction

    task automatic start_run(input logic [9:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        acc_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic flush_wait();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("busy_low", busy, 0);
    endtask

    task automatic run_stream(input logic [9:0] len, input bit bubbles);
        got.delete();
        start_run(len);
        foreach (bu[i]) begin
            bus.DI_valid = 1'b0;
            if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.DI_valid = 1'b1;
            bus.DI_uni = bu[i];
            bus.DI_wei = bw[i];
            @(posedge clk); #1;
        end
        bus.DI_valid = 1'b0;
        flush_wait();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name);
        check({name, "_n"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_r%0d", name, i), got[i], exp_q[i]);
    endtask

    task automatic fill(input logic [31:0] u, input logic [31:0] w, input int n);
        bu.delete();
        bw.delete();
        repeat (n) begin
            bu.push_back(u);
            bw.push_back(w);
        end
    endtask

    initial begin
        tbl[0] = '{32'h01020304, 32'h01010101, 10'd4, 4, 1, 32'd40, 32'd40};
        tbl[1] = '{32'hFF807F01, 32'h7F7F7F01, 10'd1, 1, 1, 32'hFFFFFF03, 32'hFFFFFF03};
        tbl[2] = '{32'h00000001, 32'h00000001, 10'd3, 7, 3, 32'd3, 32'd1};
        tbl[3] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 10'd2, 5, 3, 32'd129032, 32'd64516};
        tbl[4] = '{32'h80808080, 32'h80808080, 10'd4, 4, 1, 32'd262144, 32'd262144};
        tbl[5] = '{32'h80808080, 32'h7F7F7F7F, 10'd3, 3, 1, 32'hFFFD0600, 32'hFFFD0600};
        tbl[6] = '{32'h00000002, 32'h000000FF, 10'd10, 4, 1, 32'hFFFFFFF8, 32'hFFFFFFF8};
        start = 1'b0;
        flush = 1'b0;
        acc_len = '0;
        bus.DI_valid = 1'b0;
        bus.DI_uni = '0;
        bus.DI_wei = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_err, 0);
        rst_n = 1'b1;

        // Latency: result 3 cycles after the last beat, busy drops 3 cycles after flush.
        got.delete();
        start_run(10'd4);
        for (int i = 0; i < 4; i++) begin
            bus.DI_valid = 1'b1;
            bus.DI_uni = 32'h01020304;
            bus.DI_wei = 32'h01010101;
            @(posedge clk); #1;
        end
        bus.DI_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lat_e2_valid", bus.res_valid, 0);
        @(negedge clk);
        check("lat_e3_valid", bus.res_valid, 1);
        check("lat_e3_data", bus.res_data, 40);
        check("lat_f2_busy", busy, 1);
        @(negedge clk);
        check("lat_f3_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("lat_count", got.size(), 1);

        foreach (tbl[i]) begin
            fill(tbl[i].uni, tbl[i].wei, tbl[i].n);
            run_stream(tbl[i].len, 1'b0);
            check($sformatf("vec%0d_n", i), got.size(), tbl[i].exp_n);
            if (got.size() > 0) begin
                check($sformatf("vec%0d_first", i), got[0], tbl[i].first);
                check($sformatf("vec%0d_last", i), got[$], tbl[i].last);
            end
        end

        // Overflow: third result dropped with res_ready low, first two kept in order.
        got.delete();
        bus.res_ready = 1'b0;
        start_run(10'd1);
        for (int k = 1; k <= 3; k++) begin
            bus.DI_valid = 1'b1;
            bus.DI_uni = k;
            bus.DI_wei = 32'h00000001;
            @(posedge clk); #1;
        end
        bus.DI_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("ovf_valid", bus.res_valid, 1);
        check("ovf_flag", ovf_err, 1);
        check("ovf_head", bus.res_data, 1);
        @(negedge clk);
        check("ovf_hold", bus.res_data, 1);
        flush_wait();
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ovf_count", got.size(), 2);
        if (got.size() == 2) begin
            check("ovf_r0", got[0], 1);
            check("ovf_r1", got[1], 2);
        end

        // A clean start clears the sticky flag; start with len 0 sets it and stays idle.
        fill(32'h05050505, 32'h01FF01FF, 1);
        model(2);
        run_stream(10'd2, 1'b0);
        compare("clr");
        check("clr_ovf", ovf_err, 0);
        start_run(10'd0);
        @(negedge clk);
        check("len0_ovf", ovf_err, 1);
        check("len0_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("len0_busy2", busy, 0);

        // Reset mid-group with one FIFO entry, then a fresh run from zero.
        got.delete();
        bus.res_ready = 1'b0;
        start_run(10'd2);
        for (int i = 0; i < 3; i++) begin
            bus.DI_valid = 1'b1;
            bus.DI_uni = 32'h00000001;
            bus.DI_wei = 32'h00000001;
            @(posedge clk); #1;
        end
        bus.DI_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid", bus.res_valid, 1);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.res_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_data", bus.res_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        fill(32'h01020304, 32'h01010101, 4);
        model(4);
        run_stream(10'd4, 1'b0);
        compare("post_rst");

        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 6);
            int nb = $urandom_range(1, 16);
            bu.delete();
            bw.delete();
            repeat (nb) begin
                bu.push_back($urandom);
                bw.push_back($urandom);
            end
            model(len);
            run_stream(10'(len), 1'b1);
            compare($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_ovf", r), ovf_err, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
